// File: rtl/bsg_mem_1rw_sync_pipe_pkg.sv
// bsg_mem_1rw_sync_pipe_pkg: derived-width helpers shared by the pipelined banked RAM
package bsg_mem_1rw_sync_pipe_pkg;
    function automatic int idx_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int bank_bits_f(input int banks);
        return (banks > 1) ? $clog2(banks) : 0;
    endfunction
    function automatic int row_bits_f(input int els, input int banks);
        return idx_width_f(els / banks);
    endfunction
    function automatic int mask_width_f(input int width);
        return width / 8;
    endfunction
    function automatic int credit_width_f(input int read_lat);
        return $clog2(read_lat + 2);
    endfunction
endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port sync RAM with byte write mask
// Ports: clk_i clock; v_i access enable; w_i 1=write; addr_i word address;
//        data_i write data; write_mask_i byte enables; data_o registered read data
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int els_p         = 16,
    parameter int data_width_p  = 32,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int mask_width_lp = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]  data_o
);
    logic [data_width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int b = 0; b < mask_width_lp; b++)
                if (write_mask_i[b]) r_mem[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
        end else if (v_i) begin
            data_o <= r_mem[addr_i];
        end
    end
endmodule

// File: rtl/bsg_mem_1rw_sync_pipe_obuf.sv
// bsg_mem_1rw_sync_pipe_obuf: bypassing response FIFO plus read credit counter
// Ports: i_clk/i_rst_n clock and async active-low reset; i_v/i_data last pipeline
//        stage; i_rd_accept read accepted this cycle; i_yumi consumer dequeue;
//        o_ready credits available; o_v/o_data response toward the consumer
module bsg_mem_1rw_sync_pipe_obuf
    import bsg_mem_1rw_sync_pipe_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int read_lat_p        = 2,
    parameter int latch_last_read_p = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_v,
    input  logic [width_p-1:0] i_data,
    input  logic               i_rd_accept,
    input  logic               i_yumi,
    output logic               o_ready,
    output logic               o_v,
    output logic [width_p-1:0] o_data
);
    localparam int depth_lp = read_lat_p + 1;
    localparam int ptr_w_lp = idx_width_f(depth_lp);
    localparam int cnt_w_lp = credit_width_f(read_lat_p);

    logic [width_p-1:0]  r_mem [depth_lp];
    logic [ptr_w_lp-1:0] r_wptr, r_rptr;
    logic [cnt_w_lp-1:0] r_count, r_credits;
    logic [width_p-1:0]  r_last, w_head;
    logic                w_empty, w_enq, w_deq;

    assign w_empty = (r_count == '0);
    assign w_head  = w_empty ? i_data : r_mem[r_rptr];
    // an arriving word bypassed straight to the consumer never enters storage
    assign w_enq   = i_v & ~(w_empty & i_yumi);
    assign w_deq   = i_yumi & ~w_empty;
    assign o_v     = ~w_empty | i_v;
    assign o_ready = (r_credits != '0);
    assign o_data  = o_v ? w_head : r_last;

    always_ff @(posedge i_clk)
        if (w_enq) r_mem[r_wptr] <= i_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_credits <= cnt_w_lp'(read_lat_p + 1);
            r_last    <= '0;
        end else begin
            if (w_enq) r_wptr <= (r_wptr == ptr_w_lp'(depth_lp - 1)) ? '0 : r_wptr + 1'b1;
            if (w_deq) r_rptr <= (r_rptr == ptr_w_lp'(depth_lp - 1)) ? '0 : r_rptr + 1'b1;
            r_count   <= r_count + cnt_w_lp'(w_enq) - cnt_w_lp'(w_deq);
            r_credits <= r_credits - cnt_w_lp'(i_rd_accept) + cnt_w_lp'(i_yumi);
            if (latch_last_read_p != 0 && i_yumi) r_last <= w_head;
        end
    end
endmodule

// File: rtl/bsg_mem_1rw_sync_pipe.sv
// bsg_mem_1rw_sync_pipe: banked byte-masked 1rw RAM with read pipeline and credit backpressure
// Ports: clk_i clock; reset_n_i async active-low reset; v_i/w_i/addr_i/data_i/w_mask_i
//        request (accepted on v_i & ready_o); ready_o credit available;
//        v_o/data_o in-order read response; yumi_i consumer dequeue
module bsg_mem_1rw_sync_pipe
    import bsg_mem_1rw_sync_pipe_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int els_p             = 64,
    parameter int banks_p           = 4,
    parameter int read_lat_p        = 2,
    parameter int latch_last_read_p = 0,
    localparam int addr_width_lp    = $clog2(els_p),
    localparam int mask_w_lp        = mask_width_f(width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_w_lp-1:0]     w_mask_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i
);
    localparam int bank_bits_lp = bank_bits_f(banks_p);
    localparam int bank_w_lp    = (bank_bits_lp > 0) ? bank_bits_lp : 1;
    localparam int row_w_lp     = row_bits_f(els_p, banks_p);

    typedef struct packed {
        logic               valid;
        logic [width_p-1:0] data;
    } stage_s;

    logic                 w_accept, w_rd_accept, r_rd_v;
    logic [bank_w_lp-1:0] w_bank, r_bank;
    logic [row_w_lp-1:0]  w_row;
    logic [width_p-1:0]   w_bank_data [banks_p];
    stage_s               w_s0, w_last;

    assign w_accept    = v_i & ready_o;
    assign w_rd_accept = w_accept & ~w_i;
    assign w_bank      = (banks_p == 1) ? '0 : addr_i[bank_w_lp-1:0];
    assign w_row       = row_w_lp'(addr_i >> bank_bits_lp);

    for (genvar b = 0; b < banks_p; b++) begin : g_bank
        bsg_mem_1rw_sync_mask_write_byte #(
            .els_p       (els_p / banks_p),
            .data_width_p(width_p)
        ) u_bank (
            .clk_i       (clk_i),
            .v_i         (w_accept && (w_bank == bank_w_lp'(b))),
            .w_i         (w_i),
            .addr_i      (w_row),
            .data_i      (data_i),
            .write_mask_i(w_mask_i),
            .data_o      (w_bank_data[b])
        );
    end

    // the bank index travels with the array access so the mux picks the right bank
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_v <= 1'b0;
            r_bank <= '0;
        end else begin
            r_rd_v <= w_rd_accept;
            if (w_rd_accept) r_bank <= w_bank;
        end
    end

    assign w_s0 = '{valid: r_rd_v, data: w_bank_data[r_bank]};

    if (read_lat_p > 1) begin : g_pipe
        stage_s r_pipe [read_lat_p-1];
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                for (int i = 0; i < read_lat_p - 1; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_s0;
                for (int i = 1; i < read_lat_p - 1; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end
        assign w_last = r_pipe[read_lat_p-2];
    end else begin : g_nopipe
        assign w_last = w_s0;
    end

    bsg_mem_1rw_sync_pipe_obuf #(
        .width_p          (width_p),
        .read_lat_p       (read_lat_p),
        .latch_last_read_p(latch_last_read_p)
    ) u_obuf (
        .i_clk      (clk_i),
        .i_rst_n    (reset_n_i),
        .i_v        (w_last.valid),
        .i_data     (w_last.data),
        .i_rd_accept(w_rd_accept),
        .i_yumi     (yumi_i),
        .o_ready    (ready_o),
        .o_v        (v_o),
        .o_data     (data_o)
    );

    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
    a_width_bytes:  assert property (@(posedge clk_i) (width_p % 8) == 0);
    a_banks_pow2:   assert property (@(posedge clk_i) (banks_p & (banks_p - 1)) == 0);
    a_lat_range:    assert property (@(posedge clk_i) read_lat_p >= 1 && read_lat_p <= 4);
endmodule

// File: tb/tb_bsg_mem_1rw_sync_pipe.sv
module tb_bsg_mem_1rw_sync_pipe;
    localparam int LAT = 2;

    logic        clk, reset_n_i, v_i, w_i, yumi_i, ready_o, v_o;
    logic [5:0]  addr_i;
    logic [31:0] data_i, data_o;
    logic [3:0]  w_mask_i;

    bsg_mem_1rw_sync_pipe #(
        .width_p(32), .els_p(64), .banks_p(4), .read_lat_p(LAT), .latch_last_read_p(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
        .data_i(data_i), .w_mask_i(w_mask_i), .ready_o(ready_o), .v_o(v_o),
        .data_o(data_o), .yumi_i(yumi_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    typedef struct {
        logic        v, w;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        yumi, ev, er;
        logic [31:0] ed;
    } vec_t;

    int          checks, errors, cyc;
    logic [31:0] mdl_mem [64];
    resp_t       mdl_q [$];
    logic [31:0] mdl_last;
    logic [31:0] exp_q [$];
    vec_t        vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Call just after a negedge: compare against the model, drive, take the edge, update the model.
    task automatic drive_now(input logic v, input logic w, input logic [5:0] a,
                             input logic [31:0] d, input logic [3:0] m, input logic y);
        bit mv, mr;
        mv = mdl_q.size() > 0 && mdl_q[0].due <= cyc;
        mr = mdl_q.size() < LAT + 1;
        check("mdl_v_o", v_o, mv);
        check("mdl_ready_o", ready_o, mr);
        check("mdl_data_o", data_o, mv ? mdl_q[0].data : mdl_last);
        v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m; yumi_i = y && mv;
        @(posedge clk);
        cyc++;
        if (yumi_i) begin
            mdl_last = mdl_q[0].data;
            void'(mdl_q.pop_front());
        end
        if (v && mr) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) mdl_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                mdl_q.push_back('{data: mdl_mem[a], due: cyc + LAT - 1});
            end
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [5:0] a,
                         input logic [31:0] d, input logic [3:0] m, input logic y);
        @(negedge clk);
        drive_now(v, w, a, d, m, y);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            @(negedge clk);
            if (v_o) check("drain_data", data_o, exp_q.pop_front());
            drive_now(0, 0, 0, 0, 0, 1);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, ai;
        checks = 0; errors = 0; cyc = 0; mdl_last = 0;
        clk = 0; reset_n_i = 0; v_i = 0; w_i = 0; addr_i = 0; data_i = 0; w_mask_i = 0; yumi_i = 0;
        vecs[0] = '{v:1, w:1, addr:5, data:32'hDEADBEEF, mask:4'hF, yumi:0, ev:0, er:1, ed:32'h0};
        vecs[1] = '{v:1, w:0, addr:5, data:32'h0,        mask:4'h0, yumi:0, ev:0, er:1, ed:32'h0};
        vecs[2] = '{v:0, w:0, addr:0, data:32'h0,        mask:4'h0, yumi:0, ev:0, er:1, ed:32'h0};
        vecs[3] = '{v:0, w:0, addr:0, data:32'h0,        mask:4'h0, yumi:1, ev:1, er:1, ed:32'hDEADBEEF};
        vecs[4] = '{v:1, w:1, addr:5, data:32'h0000AA00, mask:4'h2, yumi:0, ev:0, er:1, ed:32'hDEADBEEF};
        vecs[5] = '{v:1, w:0, addr:5, data:32'h0,        mask:4'h0, yumi:0, ev:0, er:1, ed:32'hDEADBEEF};
        vecs[6] = '{v:0, w:0, addr:0, data:32'h0,        mask:4'h0, yumi:0, ev:0, er:1, ed:32'hDEADBEEF};
        vecs[7] = '{v:0, w:0, addr:0, data:32'h0,        mask:4'h0, yumi:1, ev:1, er:1, ed:32'hDEADAAEF};
        vecs[8] = '{v:0, w:0, addr:0, data:32'h0,        mask:4'h0, yumi:0, ev:0, er:1, ed:32'hDEADAAEF};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_v_o", v_o, 0);
        check("rst_ready_o", ready_o, 1);
        check("rst_data_o", data_o, 0);
        reset_n_i = 1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_v_o", i), v_o, vecs[i].ev);
            check($sformatf("vec%0d_ready_o", i), ready_o, vecs[i].er);
            check($sformatf("vec%0d_data_o", i), data_o, vecs[i].ed);
            drive_now(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].yumi);
        end

        for (int a = 0; a < 64; a++) drive(1, 1, 6'(a), a * 32'h01010101, 4'hF, 0);

        // back-to-back reads with the consumer always ready
        ai = 0; got = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(i * 32'h01010101);
        for (int c = 0; c < 60 && got < 16; c++) begin
            @(negedge clk);
            check("stream_ready", ready_o, 1);
            if (v_o) begin
                check("stream_data", data_o, exp_q.pop_front());
                got++;
            end
            drive_now(ai < 16, 0, 6'(ai), 0, 0, 1);
            if (ai < 16) ai++;
        end
        check("stream_count", got, 16);
        exp_q.delete();

        // backpressure: no dequeue, only LAT+1 reads fit
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ai = 20 + acc;
            if (ready_o) acc++;
            drive_now(1, 0, 6'(ai), 0, 0, 0);
        end
        check("bp_accepted", acc, LAT + 1);
        @(negedge clk);
        check("bp_v_o", v_o, 1);
        check("bp_ready_low", ready_o, 0);
        check("bp_first", data_o, 32'h14141414);
        drive_now(1, 0, 23, 0, 0, 1);
        @(negedge clk);
        check("bp_ready_back", ready_o, 1);
        drive_now(1, 0, 23, 0, 0, 0);
        exp_q.push_back(32'h15151515);
        exp_q.push_back(32'h16161616);
        exp_q.push_back(32'h17171717);
        drain();

        // write behind an in-flight read to the same address
        drive(1, 0, 9, 0, 0, 0);
        drive(1, 1, 9, 32'hCAFEF00D, 4'hF, 0);
        exp_q.push_back(32'h09090909);
        drain();
        drive(1, 0, 9, 0, 0, 0);
        exp_q.push_back(32'hCAFEF00D);
        drain();

        // latched output after a dequeue
        drive(1, 1, 7, 32'h12345678, 4'hF, 0);
        drive(1, 0, 7, 0, 0, 0);
        exp_q.push_back(32'h12345678);
        drain();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("latch_v_o", v_o, 0);
            check("latch_data_o", data_o, 32'h12345678);
            drive_now(0, 0, 0, 0, 0, 0);
        end

        // asynchronous reset with two reads in flight
        drive(1, 0, 3, 0, 0, 0);
        drive(1, 0, 4, 0, 0, 0);
        #3;
        v_i = 0; yumi_i = 0; reset_n_i = 0;
        #1;
        check("arst_v_o", v_o, 0);
        check("arst_ready_o", ready_o, 1);
        check("arst_data_o", data_o, 0);
        mdl_q.delete();
        mdl_last = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n_i = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale", v_o, 0);
            drive_now(0, 0, 0, 0, 0, 1);
        end
        drive(1, 0, 3, 0, 0, 0);
        exp_q.push_back(32'h03030303);
        drain();

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 6'($urandom_range(0, 63)),
                  $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 1);
        check("final_empty", mdl_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
